// File: rtl/pc_sequencer.sv
// Program-counter sequencer: PC, flag bank, jump/call/ret, start/halt FSM.
// Ports: clock/reset, control requests in; pc, flags, jump_taken, sp, running, fault out.
module pc_sequencer #(
   parameter int                ADDR_W      = 16,
   parameter int                NUM_FLAGS   = 5,
   parameter int                STACK_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               start,
   input  logic                               halt_req,
   input  logic                               step_en,
   input  logic [NUM_FLAGS-1:0]               flag_in,
   input  logic [NUM_FLAGS-1:0]               flag_upd,
   input  logic                               jump_req,
   input  logic [3:0]                         jump_cond,
   input  logic                               jump_pol,
   input  logic                               call_req,
   input  logic                               ret_req,
   input  logic [ADDR_W-1:0]                  jump_target,
   output logic [ADDR_W-1:0]                  pc,
   output logic [NUM_FLAGS-1:0]               flags,
   output logic                               jump_taken,
   output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
   output logic                               running,
   output logic                               fault
);

   localparam int SP_W  = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_HALT,
      S_FAULT
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [NUM_FLAGS-1:0] flags_q, flags_d;
   logic [SP_W-1:0]     sp_q, sp_d;
   logic                jt_q, jt_d;
   logic                running_q, fault_q;
   logic [ADDR_W-1:0]   stack_q [STACK_DEPTH];

   logic                step;
   logic                cond_true;
   logic                fault_ev;
   logic                push_en;
   logic [SP_W-1:0]     sp_m1;
   logic [IDX_W-1:0]    wr_idx, rd_idx;
   logic [ADDR_W-1:0]   pc_inc;

   assign step   = (state_q == S_RUN) && step_en;
   assign sp_m1  = sp_q - SP_W'(1);
   assign wr_idx = sp_q[IDX_W-1:0];
   assign rd_idx = sp_m1[IDX_W-1:0];
   assign pc_inc = pc_q + ADDR_W'(1);

   // Code 0 is unconditional; codes past the flag bank never match.
   always_comb begin
      cond_true = (jump_cond == 4'd0);
      for (int i = 0; i < NUM_FLAGS; i++) begin
         if (jump_cond == 4'(i + 1)) cond_true = flags_q[i];
      end
   end

   always_comb begin
      pc_d     = pc_q;
      flags_d  = flags_q;
      sp_d     = sp_q;
      jt_d     = 1'b0;
      fault_ev = 1'b0;
      push_en  = 1'b0;
      if (step) begin
         flags_d = (flags_q & ~flag_upd) | (flag_in & flag_upd);
         if (ret_req) begin
            if (sp_q != '0) begin
               pc_d = stack_q[rd_idx];
               sp_d = sp_m1;
               jt_d = 1'b1;
            end else begin
               fault_ev = 1'b1;
            end
         end else if (call_req) begin
            if (sp_q < SP_W'(STACK_DEPTH)) begin
               pc_d    = jump_target;
               sp_d    = sp_q + SP_W'(1);
               jt_d    = 1'b1;
               push_en = 1'b1;
            end else begin
               fault_ev = 1'b1;
            end
         end else if (jump_req && (cond_true == jump_pol)) begin
            pc_d = jump_target;
            jt_d = 1'b1;
         end else begin
            pc_d = pc_inc;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN: begin
            if (fault_ev)      state_d = S_FAULT;
            else if (halt_req) state_d = S_HALT;
         end
         S_HALT:  if (start) state_d = S_RUN;
         S_FAULT: state_d = S_FAULT;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_PC;
         flags_q   <= '0;
         sp_q      <= '0;
         jt_q      <= 1'b0;
         running_q <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         flags_q   <= flags_d;
         sp_q      <= sp_d;
         jt_q      <= jt_d;
         running_q <= (state_d == S_RUN);
         fault_q   <= (state_d == S_FAULT);
      end
   end

   // Stack contents need no reset; sp alone defines what is valid.
   always_ff @(posedge clock) begin
      if (push_en) stack_q[wr_idx] <= pc_inc;
   end

   assign pc         = pc_q;
   assign flags      = flags_q;
   assign sp         = sp_q;
   assign jump_taken = jt_q;
   assign running    = running_q;
   assign fault      = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios plus randomized run
// against a queue-based reference model.
module tb_pc_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start, halt_req, step_en;
   logic [4:0]  flag_in, flag_upd;
   logic        jump_req;
   logic [3:0]  jump_cond;
   logic        jump_pol, call_req, ret_req;
   logic [15:0] jump_target;
   logic [15:0] pc;
   logic [4:0]  flags;
   logic        jump_taken;
   logic [2:0]  sp;
   logic        running, fault;

   int checks = 0;
   int failures = 0;

   // Reference model state: 0 idle, 1 run, 2 halt, 3 fault
   int          mst;
   logic [15:0] mpc;
   logic [4:0]  mflags;
   logic        mjt;
   logic [15:0] mstack[$];

   pc_sequencer dut (
      .clock(clock), .reset(reset), .start(start), .halt_req(halt_req),
      .step_en(step_en), .flag_in(flag_in), .flag_upd(flag_upd),
      .jump_req(jump_req), .jump_cond(jump_cond), .jump_pol(jump_pol),
      .call_req(call_req), .ret_req(ret_req), .jump_target(jump_target),
      .pc(pc), .flags(flags), .jump_taken(jump_taken), .sp(sp),
      .running(running), .fault(fault)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic clr_in();
      start = 0; halt_req = 0; step_en = 0; flag_in = 0; flag_upd = 0;
      jump_req = 0; jump_cond = 0; jump_pol = 0; call_req = 0;
      ret_req = 0; jump_target = 0;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      clr_in();
      #1 reset = 1;
      #2 reset = 0;
      tick();
   endtask

   task automatic do_start();
      clr_in();
      start = 1;
      tick();
      clr_in();
   endtask

   task automatic goto_pc(input logic [15:0] a);
      clr_in();
      step_en = 1; jump_req = 1; jump_cond = 0; jump_pol = 1;
      jump_target = a;
      tick();
      clr_in();
   endtask

   function automatic logic cond_of(input logic [4:0] f, input int code);
      if (code == 0) return 1'b1;
      if (code <= 5) return f[code-1];
      return 1'b0;
   endfunction

   task automatic model_reset();
      mst = 0; mpc = 16'h0; mflags = 0; mjt = 0;
      mstack.delete();
   endtask

   task automatic model_edge();
      logic flt;
      flt = 0;
      mjt = 0;
      if (mst == 1 && step_en) begin
         if (ret_req) begin
            if (mstack.size() > 0) begin
               mpc = mstack.pop_back(); mjt = 1;
            end else flt = 1;
         end else if (call_req) begin
            if (mstack.size() < 4) begin
               mstack.push_back(mpc + 16'd1);
               mpc = jump_target; mjt = 1;
            end else flt = 1;
         end else if (jump_req && cond_of(mflags, jump_cond) == jump_pol) begin
            mpc = jump_target; mjt = 1;
         end else begin
            mpc = mpc + 16'd1;
         end
         mflags = (mflags & ~flag_upd) | (flag_in & flag_upd);
      end
      case (mst)
         0: if (start) mst = 1;
         1: if (flt) mst = 3; else if (halt_req) mst = 2;
         2: if (start) mst = 1;
         default: mst = 3;
      endcase
   endtask

   task automatic test_reset();
      clr_in();
      tick();
      #1 reset = 1;
      #1;
      checks++;
      if (pc !== 16'h0 || flags !== 5'h0 || sp !== 3'd0) begin
         failures++;
         $display("FAIL reset_regs: pc=%h flags=%b sp=%0d want 0", pc, flags, sp);
      end
      checks++;
      if (jump_taken !== 1'b0 || running !== 1'b0 || fault !== 1'b0) begin
         failures++;
         $display("FAIL reset_status: jt=%b run=%b flt=%b want 0", jump_taken, running, fault);
      end
      reset = 0;
      tick();
   endtask

   task automatic test_increment();
      do_reset();
      do_start();
      checks++;
      if (running !== 1'b1 || pc !== 16'h0) begin
         failures++;
         $display("FAIL start: run=%b pc=%h want 1/0000", running, pc);
      end
      for (int i = 1; i <= 3; i++) begin
         step_en = 1;
         tick();
         checks++;
         if (pc !== 16'(i) || jump_taken !== 1'b0 || running !== 1'b1) begin
            failures++;
            $display("FAIL incr%0d: pc=%h jt=%b run=%b want %h/0/1", i, pc, jump_taken, running, 16'(i));
         end
      end
      clr_in();
   endtask

   task automatic test_jump_flag();
      step_en = 1; flag_upd = 5'b00001; flag_in = 5'b00001;
      tick();
      clr_in();
      step_en = 1; jump_req = 1; jump_cond = 1; jump_pol = 1; jump_target = 16'h40;
      tick();
      checks++;
      if (pc !== 16'h0040 || jump_taken !== 1'b1) begin
         failures++;
         $display("FAIL jump_pol1: pc=%h jt=%b want 0040/1", pc, jump_taken);
      end
      jump_pol = 0;
      tick();
      checks++;
      if (pc !== 16'h0041 || jump_taken !== 1'b0) begin
         failures++;
         $display("FAIL jump_pol0: pc=%h jt=%b want 0041/0", pc, jump_taken);
      end
      clr_in();
      tick();
      checks++;
      if (pc !== 16'h0041 || jump_taken !== 1'b0) begin
         failures++;
         $display("FAIL hold_no_step: pc=%h jt=%b want 0041/0", pc, jump_taken);
      end
   endtask

   task automatic test_same_cycle_flag();
      do_reset();
      do_start();
      step_en = 1; flag_upd = 5'b00001; flag_in = 5'b00001;
      jump_req = 1; jump_cond = 1; jump_pol = 1; jump_target = 16'h40;
      tick();
      checks++;
      if (pc !== 16'h0001 || jump_taken !== 1'b0 || flags !== 5'b00001) begin
         failures++;
         $display("FAIL same_cycle: pc=%h jt=%b flags=%b want 0001/0/00001", pc, jump_taken, flags);
      end
      clr_in();
   endtask

   task automatic test_call_overflow();
      do_reset();
      do_start();
      goto_pc(16'h10);
      for (int i = 1; i <= 4; i++) begin
         step_en = 1; call_req = 1; jump_target = 16'h80;
         tick();
         checks++;
         if (sp !== 3'(i) || pc !== 16'h80 || jump_taken !== 1'b1) begin
            failures++;
            $display("FAIL call%0d: sp=%0d pc=%h jt=%b want %0d/0080/1", i, sp, pc, jump_taken, i);
         end
      end
      tick();
      checks++;
      if (sp !== 3'd4 || fault !== 1'b1 || pc !== 16'h80 || running !== 1'b0) begin
         failures++;
         $display("FAIL overflow: sp=%0d flt=%b pc=%h run=%b want 4/1/0080/0", sp, fault, pc, running);
      end
      do_reset();
      do_start();
      goto_pc(16'h10);
      step_en = 1; call_req = 1; jump_target = 16'h80;
      tick();
      clr_in();
      step_en = 1; ret_req = 1;
      tick();
      checks++;
      if (pc !== 16'h0011 || sp !== 3'd0 || jump_taken !== 1'b1) begin
         failures++;
         $display("FAIL call_ret: pc=%h sp=%0d jt=%b want 0011/0/1", pc, sp, jump_taken);
      end
      clr_in();
   endtask

   task automatic test_underflow();
      do_reset();
      do_start();
      step_en = 1; ret_req = 1;
      tick();
      checks++;
      if (fault !== 1'b1 || pc !== 16'h0 || sp !== 3'd0) begin
         failures++;
         $display("FAIL underflow: flt=%b pc=%h sp=%0d want 1/0000/0", fault, pc, sp);
      end
      do_start();
      checks++;
      if (fault !== 1'b1 || running !== 1'b0) begin
         failures++;
         $display("FAIL fault_sticky: flt=%b run=%b want 1/0", fault, running);
      end
   endtask

   task automatic test_wrap_halt();
      do_reset();
      do_start();
      goto_pc(16'hFFFF);
      step_en = 1;
      tick();
      checks++;
      if (pc !== 16'h0000) begin
         failures++;
         $display("FAIL wrap: pc=%h want 0000", pc);
      end
      clr_in();
      halt_req = 1;
      tick();
      clr_in();
      step_en = 1;
      tick();
      tick();
      checks++;
      if (pc !== 16'h0000 || running !== 1'b0 || jump_taken !== 1'b0) begin
         failures++;
         $display("FAIL halt_hold: pc=%h run=%b jt=%b want 0000/0/0", pc, running, jump_taken);
      end
      do_start();
      step_en = 1;
      tick();
      checks++;
      if (pc !== 16'h0001 || running !== 1'b1) begin
         failures++;
         $display("FAIL resume: pc=%h run=%b want 0001/1", pc, running);
      end
      step_en = 1; call_req = 1; jump_target = 16'h200;
      tick();
      #2 reset = 1;
      #1;
      checks++;
      if (pc !== 16'h0 || sp !== 3'd0 || running !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid: pc=%h sp=%0d run=%b want 0000/0/0", pc, sp, running);
      end
      reset = 0;
      tick();
      checks++;
      if (pc !== 16'h0 || running !== 1'b0 || fault !== 1'b0) begin
         failures++;
         $display("FAIL idle_after_reset: pc=%h run=%b flt=%b want 0000/0/0", pc, running, fault);
      end
      clr_in();
   endtask

   task automatic test_random();
      int bad;
      bad = 0;
      do_reset();
      model_reset();
      for (int n = 0; n < 600; n++) begin
         if (mst == 3) begin
            do_reset();
            model_reset();
         end
         start       = ($urandom_range(0, 9) == 0);
         halt_req    = ($urandom_range(0, 24) == 0);
         step_en     = ($urandom_range(0, 3) != 0);
         flag_in     = 5'($urandom);
         flag_upd    = 5'($urandom);
         jump_req    = $urandom_range(0, 1);
         jump_cond   = 4'($urandom_range(0, 7));
         jump_pol    = $urandom_range(0, 1);
         call_req    = ($urandom_range(0, 5) == 0);
         ret_req     = ($urandom_range(0, 6) == 0);
         jump_target = 16'($urandom);
         if (n < 20) start = 1;
         model_edge();
         tick();
         checks++;
         if (pc !== mpc || flags !== mflags || sp !== 3'(mstack.size()) ||
             jump_taken !== mjt || running !== (mst == 1) || fault !== (mst == 3)) begin
            failures++;
            bad++;
            if (bad <= 5)
               $display("FAIL rand%0d: pc=%h fl=%b sp=%0d jt=%b run=%b flt=%b want %h/%b/%0d/%b/%b/%b",
                        n, pc, flags, sp, jump_taken, running, fault,
                        mpc, mflags, mstack.size(), mjt, mst == 1, mst == 3);
         end
      end
      clr_in();
   endtask

   initial begin
      clr_in();
      test_reset();
      test_increment();
      test_jump_flag();
      test_same_cycle_flag();
      test_call_overflow();
      test_underflow();
      test_wrap_halt();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
